// File: rtl/cpu2.sv
// rtl/cpu2.sv - 8-bit accumulator CPU with 4-bit address space and fetch/execute sequencer
module cpu2 (
    input  logic       clk,
    input  logic       reset,
    output logic       read,
    output logic       write,
    input  logic [7:0] memoryOut,
    output logic [7:0] memoryIn,
    output logic [3:0] address
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_EXECUTE = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [3:0] OP_HALT  = 4'b0000;
    localparam logic [3:0] OP_AND   = 4'b0001;
    localparam logic [3:0] OP_XNOR  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_LOAD  = 4'b0100;
    localparam logic [3:0] OP_STORE = 4'b0101;
    localparam logic [3:0] OP_JMP   = 4'b0110;
    localparam logic [3:0] OP_JZ    = 4'b0111;

    state_t     state;
    state_t     next_state;
    logic [3:0] pc;
    logic [7:0] ir;
    logic [7:0] ac;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       mem_read_op;

    assign opcode   = ir[7:4];
    assign operand  = ir[3:0];
    assign memoryIn = ac;

    always_comb begin
        mem_read_op = 1'b0;
        case (opcode)
            OP_AND, OP_XNOR, OP_ADD, OP_LOAD: mem_read_op = 1'b1;
            default:                          mem_read_op = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:   next_state = S_EXECUTE;
            S_EXECUTE: next_state = (opcode == OP_HALT) ? S_HALT : S_FETCH;
            S_HALT:    next_state = S_HALT;
            default:   next_state = S_FETCH;
        endcase
    end

    // Strobes are forced low while reset is held so a pending STORE can never reach memory.
    always_comb begin
        read    = 1'b0;
        write   = 1'b0;
        address = pc;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    read    = 1'b1;
                    address = pc;
                end
                S_EXECUTE: begin
                    address = operand;
                    read    = mem_read_op;
                    write   = (opcode == OP_STORE);
                end
                default: begin
                    address = pc;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 4'd0;
            ir <= 8'd0;
            ac <= 8'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= memoryOut;
                    pc <= pc + 4'd1;
                end
                S_EXECUTE: begin
                    case (opcode)
                        OP_AND:  ac <= ac & memoryOut;
                        OP_XNOR: ac <= ~(ac ^ memoryOut);
                        OP_ADD:  ac <= ac + memoryOut;
                        OP_LOAD: ac <= memoryOut;
                        OP_JMP:  pc <= operand;
                        OP_JZ: begin
                            if (ac == 8'd0) begin
                                pc <= operand;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu2.sv
// tb/tb_cpu2.sv - scoreboard bench for cpu2 running small programs against a 16x8 memory
module tb_cpu2;

    logic       clk;
    logic       reset;
    logic       read;
    logic       write;
    logic [7:0] memoryOut;
    logic [7:0] memoryIn;
    logic [3:0] address;

    logic [7:0] mem [16];
    logic [7:0] prog [16];
    logic       ld_en;
    logic [3:0] ld_addr;
    logic [7:0] ld_data;

    int total;
    int bad;
    int cyc;

    localparam int K_AC   = 0;
    localparam int K_MEM  = 1;
    localparam int K_ADDR = 2;
    localparam int K_RD   = 3;
    localparam int K_WR   = 4;

    typedef struct {
        int         c;
        int         kind;
        logic [3:0] a;
        logic [7:0] v;
        string      tag;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [7:0] v;
    } st_t;

    exp_t sb[$];
    st_t  sq[$];

    cpu2 dut (
        .clk       (clk),
        .reset     (reset),
        .read      (read),
        .write     (write),
        .memoryOut (memoryOut),
        .memoryIn  (memoryIn),
        .address   (address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign memoryOut = mem[address];

    always @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (write) begin
            mem[address] <= memoryIn;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_at(input int c, input int kind, input logic [3:0] a,
                             input logic [7:0] v, input string tag);
        exp_t e;
        e.c = c; e.kind = kind; e.a = a; e.v = v; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic expect_store(input logic [3:0] a, input logic [7:0] v);
        st_t s;
        s.a = a; s.v = v;
        sq.push_back(s);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    // Loads prog into memory with reset held, then releases reset on a falling edge.
    task automatic start();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ld_en   = 1'b1;
            ld_addr = 4'(i);
            ld_data = prog[i];
            @(negedge clk);
        end
        ld_en = 1'b0;
        sb.delete();
        sq.delete();
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic monitor();
        exp_t e;
        st_t  s;
        chk("rw_exclusive", {31'd0, read & write}, 32'd0);
        if (write) begin
            if (sq.size() == 0) begin
                chk("unexpected_store", 32'd1, 32'd0);
            end else begin
                s = sq.pop_front();
                chk("store_addr", {28'd0, address}, {28'd0, s.a});
                chk("store_data", {24'd0, memoryIn}, {24'd0, s.v});
            end
        end
        while (sb.size() > 0 && sb[0].c <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_AC:    chk(e.tag, {24'd0, memoryIn}, {24'd0, e.v});
                K_MEM:   chk(e.tag, {24'd0, mem[e.a]}, {24'd0, e.v});
                K_ADDR:  chk(e.tag, {28'd0, address}, {24'd0, e.v});
                K_RD:    chk(e.tag, {31'd0, read}, {24'd0, e.v});
                default: chk(e.tag, {31'd0, write}, {24'd0, e.v});
            endcase
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            monitor();
        end
    endtask

    task automatic finish_test(input string name);
        chk({name, "_sb_left"}, sb.size(), 32'd0);
        chk({name, "_store_left"}, sq.size(), 32'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        cyc     = 0;
        ld_en   = 1'b0;
        ld_addr = 4'd0;
        ld_data = 8'd0;
        reset   = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk("rst_read", {31'd0, read}, 32'd0);
        chk("rst_write", {31'd0, write}, 32'd0);
        chk("rst_address", {28'd0, address}, 32'd0);
        chk("rst_memoryIn", {24'd0, memoryIn}, 32'd0);

        // XNOR program
        clear_prog();
        prog[0] = 8'h45; prog[1] = 8'h26; prog[2] = 8'h56; prog[3] = 8'h06;
        prog[5] = 8'h0A; prog[6] = 8'h05;
        start();
        expect_at(2, K_AC, 4'd0, 8'h0A, "xnor_ac_load");
        expect_at(4, K_AC, 4'd0, 8'hF0, "xnor_ac_xnor");
        expect_store(4'd6, 8'hF0);
        expect_at(6, K_MEM, 4'd6, 8'hF0, "xnor_mem6");
        expect_at(8, K_RD, 4'd0, 8'd0, "halt_read");
        expect_at(8, K_WR, 4'd0, 8'd0, "halt_write");
        expect_at(8, K_ADDR, 4'd0, 8'd4, "halt_addr");
        expect_at(10, K_RD, 4'd0, 8'd0, "halt_read_held");
        expect_at(10, K_ADDR, 4'd0, 8'd4, "halt_addr_held");
        run(10);
        finish_test("xnor");

        // Reset asserted during EXECUTE of a STORE
        clear_prog();
        prog[0] = 8'h4B; prog[1] = 8'h5A; prog[10] = 8'h77; prog[11] = 8'h33;
        start();
        expect_at(2, K_AC, 4'd0, 8'h33, "rst_pre_ac");
        expect_store(4'd10, 8'h33);
        run(3);
        #1 reset = 1'b0;
        #1;
        chk("abort_read", {31'd0, read}, 32'd0);
        chk("abort_write", {31'd0, write}, 32'd0);
        chk("abort_address", {28'd0, address}, 32'd0);
        chk("abort_memoryIn", {24'd0, memoryIn}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("abort_mem_kept", {24'd0, mem[10]}, 32'h77);
        reset = 1'b1;
        cyc = 0;
        #1;
        chk("resume_addr0", {28'd0, address}, 32'd0);
        chk("resume_read", {31'd0, read}, 32'd1);
        expect_at(1, K_ADDR, 4'd0, 8'h0B, "resume_exec_addr");
        run(1);
        finish_test("reset");

        // ADD wraps modulo 256
        clear_prog();
        prog[0] = 8'h4A; prog[1] = 8'h3B; prog[2] = 8'h00;
        prog[10] = 8'hFF; prog[11] = 8'h02;
        start();
        expect_at(2, K_AC, 4'd0, 8'hFF, "add_load");
        expect_at(4, K_AC, 4'd0, 8'h01, "add_wrap");
        expect_at(6, K_ADDR, 4'd0, 8'd3, "add_halt_addr");
        expect_at(6, K_AC, 4'd0, 8'h01, "add_ac_kept");
        run(7);
        finish_test("add");

        // AND to zero, JZ taken
        clear_prog();
        prog[0] = 8'h4A; prog[1] = 8'h1B; prog[2] = 8'h79; prog[3] = 8'h80;
        prog[9] = 8'h00; prog[10] = 8'hF0; prog[11] = 8'h0F;
        start();
        expect_at(4, K_AC, 4'd0, 8'h00, "and_zero");
        expect_at(6, K_ADDR, 4'd0, 8'd9, "jz_taken");
        expect_at(6, K_RD, 4'd0, 8'd1, "jz_fetch_read");
        expect_at(8, K_ADDR, 4'd0, 8'd10, "jz_halt_addr");
        expect_at(8, K_RD, 4'd0, 8'd0, "jz_halt_read");
        run(9);
        finish_test("jz_taken");

        // JZ falls through when AC is nonzero
        clear_prog();
        prog[0] = 8'h4A; prog[1] = 8'h79; prog[2] = 8'h00;
        prog[9] = 8'h80; prog[10] = 8'h01;
        start();
        expect_at(2, K_AC, 4'd0, 8'h01, "jz_nt_ac");
        expect_at(3, K_RD, 4'd0, 8'd0, "jz_no_read");
        expect_at(4, K_ADDR, 4'd0, 8'd2, "jz_fall_through");
        expect_at(6, K_ADDR, 4'd0, 8'd3, "jz_nt_halt_addr");
        run(7);
        finish_test("jz_not");

        // PC wraps from 15 to 0
        clear_prog();
        prog[0] = 8'h6F; prog[15] = 8'h80;
        start();
        expect_at(1, K_RD, 4'd0, 8'd0, "jmp_no_read");
        expect_at(2, K_ADDR, 4'd0, 8'd15, "jmp_target");
        expect_at(3, K_RD, 4'd0, 8'd0, "nop_no_read");
        expect_at(3, K_WR, 4'd0, 8'd0, "nop_no_write");
        expect_at(4, K_ADDR, 4'd0, 8'd0, "pc_wrap_addr");
        expect_at(4, K_RD, 4'd0, 8'd1, "pc_wrap_read");
        run(6);
        finish_test("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
